// File: rtl/syscall_pkg.sv
// Shared definitions for the hardware SYSCALL responder: service codes,
// ASCII constants, FSM states and the power-of-ten table for decimal printing.
package syscall_pkg;

  localparam logic [31:0] SC_PRINT_INT = 32'd1;
  localparam logic [31:0] SC_PRINT_STR = 32'd4;
  localparam logic [31:0] SC_EXIT      = 32'd10;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [3:0] {
    IDLE,
    INT_SIGN,
    INT_DIGIT,
    STR_REQ,
    STR_WAIT,
    STR_EMIT,
    DONE,
    ERR,
    HALT
  } state_t;

  localparam logic [31:0] POW10 [10] = '{
    32'd1,
    32'd10,
    32'd100,
    32'd1000,
    32'd10000,
    32'd100000,
    32'd1000000,
    32'd10000000,
    32'd100000000,
    32'd1000000000
  };

  function automatic logic [31:0] pow10(input logic [3:0] k);
    return (k <= 4'd9) ? POW10[k] : 32'd0;
  endfunction

endpackage

// File: rtl/syscall_unit_dec_gen.sv
// Magnitude-to-decimal sequencer: repeated subtraction of 10^k for k=9..0,
// leading zeros suppressed, one digit offered at a time on a valid/ready pair.
module syscall_dec_gen
  import syscall_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] mag,
  output logic        digit_valid,
  output logic [3:0]  digit,
  input  logic        digit_ready,
  output logic        last
);

  logic        run;
  logic [3:0]  k;
  logic [31:0] rem;
  logic [3:0]  cnt;
  logic        seen;
  logic [31:0] p;
  logic        ge;
  logic        emit;

  always_comb begin
    p           = pow10(k);
    ge          = (rem >= p);
    emit        = (cnt != 4'd0) || seen || (k == 4'd0);
    digit_valid = run && !ge && emit;
    digit       = cnt;
    last        = digit_valid && digit_ready && (k == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run  <= 1'b0;
      k    <= '0;
      rem  <= '0;
      cnt  <= '0;
      seen <= 1'b0;
    end else if (start) begin
      run  <= 1'b1;
      k    <= 4'd9;
      rem  <= mag;
      cnt  <= '0;
      seen <= 1'b0;
    end else if (run) begin
      if (ge) begin
        rem <= rem - p;
        cnt <= cnt + 4'd1;
      end else if (!emit) begin
        // suppressed leading zero: skip to the next power without a handshake
        k <= k - 4'd1;
      end else if (digit_ready) begin
        cnt  <= '0;
        seen <= 1'b1;
        if (k == 4'd0) run <= 1'b0;
        else           k   <= k - 4'd1;
      end
    end
  end

endmodule

// File: rtl/syscall_unit.sv
// SYSCALL responder: services print_int, print_string and exit, stalling the
// pipeline and streaming ASCII characters on a valid/ready byte interface.
module syscall_unit
  import syscall_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int MAX_STR = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sc_valid,
  input  logic [31:0]       sc_v0,
  input  logic [31:0]       sc_a0,
  output logic              stall,
  output logic              sc_done,
  output logic              halt,
  output logic              err_invalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready
);

  localparam int PW = ADDR_W + 2;
  localparam int CW = $clog2(MAX_STR + 1);

  state_t          state, state_nx;
  logic [31:0]     a0_q;
  logic [31:0]     word_q;
  logic [PW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            halt_seen;

  logic            dec_start;
  logic            dec_valid;
  logic            dec_ready;
  logic            dec_last;
  logic [3:0]      dec_digit;
  logic [31:0]     mag;
  logic [7:0]      str_byte;
  logic            xfer;

  always_comb begin
    mag      = a0_q[31] ? (~a0_q + 32'd1) : a0_q;
    str_byte = word_q[{ptr_q[1:0], 3'b000} +: 8];
    xfer     = out_valid && out_ready;
  end

  syscall_dec_gen u_dec (
    .clk         (clk),
    .rst         (rst),
    .start       (dec_start),
    .mag         (mag),
    .digit_valid (dec_valid),
    .digit       (dec_digit),
    .digit_ready (dec_ready),
    .last        (dec_last)
  );

  always_comb begin
    state_nx    = state;
    stall       = 1'b0;
    sc_done     = 1'b0;
    halt        = 1'b0;
    err_invalid = 1'b0;
    mem_ren     = 1'b0;
    mem_addr    = '0;
    out_valid   = 1'b0;
    out_data    = '0;
    dec_start   = 1'b0;
    dec_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (sc_valid) begin
          stall = 1'b1;
          case (sc_v0)
            SC_PRINT_INT: state_nx = INT_SIGN;
            SC_PRINT_STR: state_nx = STR_REQ;
            SC_EXIT:      state_nx = HALT;
            default:      state_nx = ERR;
          endcase
        end
      end
      INT_SIGN: begin
        stall = 1'b1;
        if (a0_q[31]) begin
          out_valid = 1'b1;
          out_data  = ASCII_MINUS;
          if (out_ready) begin
            dec_start = 1'b1;
            state_nx  = INT_DIGIT;
          end
        end else begin
          dec_start = 1'b1;
          state_nx  = INT_DIGIT;
        end
      end
      INT_DIGIT: begin
        stall     = 1'b1;
        out_valid = dec_valid;
        out_data  = ASCII_ZERO + {4'h0, dec_digit};
        dec_ready = out_ready;
        if (dec_last) state_nx = DONE;
      end
      STR_REQ: begin
        stall    = 1'b1;
        mem_ren  = 1'b1;
        mem_addr = ptr_q[PW-1:2];
        state_nx = STR_WAIT;
      end
      STR_WAIT: begin
        stall    = 1'b1;
        state_nx = STR_EMIT;
      end
      STR_EMIT: begin
        stall = 1'b1;
        if (str_byte == 8'h00) begin
          state_nx = DONE;
        end else begin
          out_valid = 1'b1;
          out_data  = str_byte;
          if (out_ready) begin
            if (cnt_q == CW'(MAX_STR - 1)) state_nx = ERR;
            else if (ptr_q[1:0] == 2'd3)   state_nx = STR_REQ;
          end
        end
      end
      DONE: begin
        sc_done  = 1'b1;
        state_nx = IDLE;
      end
      ERR: begin
        sc_done     = 1'b1;
        err_invalid = 1'b1;
        state_nx    = IDLE;
      end
      HALT: begin
        halt    = 1'b1;
        stall   = 1'b1;
        sc_done = !halt_seen;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a0_q      <= '0;
      word_q    <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      halt_seen <= 1'b0;
    end else begin
      state     <= state_nx;
      halt_seen <= (state == HALT);
      if (state == IDLE && sc_valid) begin
        a0_q  <= sc_a0;
        ptr_q <= sc_a0[PW-1:0];
        cnt_q <= '0;
      end
      if (state == STR_WAIT) word_q <= mem_rdata;
      if (state == STR_EMIT && xfer) begin
        ptr_q <= ptr_q + 1'b1;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit: directed and randomized services
// compared against a string-level reference model.
module tb_syscall_unit;

  localparam int AW   = 10;
  localparam int MAXS = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          sc_valid;
  logic [31:0]   sc_v0;
  logic [31:0]   sc_a0;
  logic          stall;
  logic          sc_done;
  logic          halt;
  logic          err_invalid;
  logic [AW-1:0] mem_addr;
  logic          mem_ren;
  logic [31:0]   mem_rdata;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int read_cnt = 0;
  byte unsigned got[$];
  bit rand_ready = 1'b0;
  logic [31:0] mem [1024];

  syscall_unit #(.ADDR_W(AW), .MAX_STR(MAXS)) dut (
    .clk         (clk),
    .rst         (rst),
    .sc_valid    (sc_valid),
    .sc_v0       (sc_v0),
    .sc_a0       (sc_a0),
    .stall       (stall),
    .sc_done     (sc_done),
    .halt        (halt),
    .err_invalid (err_invalid),
    .mem_addr    (mem_addr),
    .mem_ren     (mem_ren),
    .mem_rdata   (mem_rdata),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) got.push_back(out_data);
      if (sc_done) done_cnt++;
      if (err_invalid) err_cnt++;
      if (mem_ren) read_cnt++;
    end
  end

  task automatic tick;
    @(negedge clk);
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic string got_str(input int from);
    string s;
    s = "";
    for (int i = from; i < got.size(); i++) s = $sformatf("%s%c", s, got[i]);
    return s;
  endfunction

  // Reference: walk bytes from the byte address, little-endian within words.
  task automatic str_model(input logic [31:0] a0, output string s,
                           output int errs, output int reads);
    int unsigned p;
    int unsigned b;
    int n;
    s = ""; errs = 0; reads = 1; n = 0;
    p = a0 % 4096;
    forever begin
      b = (mem[p / 4] >> (8 * (p % 4))) & 32'hFF;
      if (b == 0) break;
      s = $sformatf("%s%c", s, b[7:0]);
      n++;
      if (n == MAXS) begin errs = 1; break; end
      p = (p + 1) % 4096;
      if (p % 4 == 0) reads++;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; sc_valid = 1'b0; sc_v0 = '0; sc_a0 = '0; out_ready = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic issue(input logic [31:0] v0, input logic [31:0] a0);
    sc_v0 = v0; sc_a0 = a0; sc_valid = 1'b1;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL req_stall: stall=%b required 1", stall);
    end
    tick;
    sc_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt > d0) begin ok = 1'b1; break; end
      tick;
    end
  endtask

  task automatic check_service(input string name, input logic [31:0] v0,
                               input logic [31:0] a0, input string exp,
                               input int exp_err, input int exp_reads);
    int d0, e0, r0, g0;
    bit ok;
    string act;
    d0 = done_cnt; e0 = err_cnt; r0 = read_cnt; g0 = got.size();
    issue(v0, a0);
    wait_done(d0, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL %s_timeout: no sc_done within budget", name);
    end
    act = got_str(g0);
    total++;
    if (act != exp) begin
      bad++; $display("FAIL %s_text: got \"%s\" required \"%s\"", name, act, exp);
    end
    total++;
    if (err_cnt - e0 !== exp_err || done_cnt - d0 !== 1) begin
      bad++; $display("FAIL %s_pulses: err=%0d done=%0d required err=%0d done=1",
                      name, err_cnt - e0, done_cnt - d0, exp_err);
    end
    if (exp_reads >= 0) begin
      total++;
      if (read_cnt - r0 !== exp_reads) begin
        bad++; $display("FAIL %s_reads: got %0d required %0d", name, read_cnt - r0, exp_reads);
      end
    end
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL %s_stall_after: stall=%b required 0", name, stall);
    end
  endtask

  task automatic test_reset;
    total++;
    if ({stall, sc_done, halt, err_invalid, mem_ren, out_valid} !== 6'b0 ||
        mem_addr !== '0 || out_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: st=%b dn=%b h=%b e=%b ren=%b ov=%b addr=%h od=%h required all 0",
               stall, sc_done, halt, err_invalid, mem_ren, out_valid, mem_addr, out_data);
    end
  endtask

  task automatic test_print_int;
    logic [31:0] a;
    rand_ready = 1'b0; out_ready = 1'b1;
    check_service("int_1234", 32'd1, 32'd1234, "1234", 0, 0);
    check_service("int_0", 32'd1, 32'd0, "0", 0, 0);
    check_service("int_m7", 32'd1, 32'hFFFF_FFF9, "-7", 0, 0);
    check_service("int_min", 32'd1, 32'h8000_0000, "-2147483648", 0, 0);
    check_service("int_max", 32'd1, 32'h7FFF_FFFF, "2147483647", 0, 0);
    rand_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      if (i % 3 == 0) a = a % 1000;
      check_service("int_rand", 32'd1, a, $sformatf("%0d", $signed(a)), 0, 0);
    end
    rand_ready = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_print_string;
    check_service("str_hello", 32'd4, 32'h10, "Hello!", 0, 2);
    check_service("str_lo", 32'd4, 32'h13, "lo!", 0, 2);
  endtask

  task automatic test_backpressure;
    int d0, r0, g0, n;
    bit ok;
    d0 = done_cnt; r0 = read_cnt; g0 = got.size();
    out_ready = 1'b0;
    issue(32'd4, 32'h10);
    n = 0;
    while (!out_valid && n < 20) begin tick; n++; end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h65 || stall !== 1'b1) begin
        bad++; $display("FAIL bp_hold: ov=%b od=%h st=%b required 1 65 1",
                        out_valid, out_data, stall);
      end
      tick;
    end
    total++;
    if (read_cnt - r0 !== 1) begin
      bad++; $display("FAIL bp_reads_held: got %0d required 1", read_cnt - r0);
    end
    out_ready = 1'b1;
    wait_done(d0, ok);
    total++;
    if (!ok || got_str(g0) != "Hello!" || read_cnt - r0 !== 2) begin
      bad++; $display("FAIL bp_result: ok=%b text=\"%s\" reads=%0d required Hello! 2",
                      ok, got_str(g0), read_cnt - r0);
    end
  endtask

  task automatic test_overrun;
    string s; int e, r;
    str_model(32'h20, s, e, r);
    check_service("str_overrun", 32'd4, 32'h20, "ABCDEFGH", 1, 2);
    total++;
    if (s != "ABCDEFGH" || e != 1) begin
      bad++; $display("FAIL overrun_model: got \"%s\" err=%0d required ABCDEFGH 1", s, e);
    end
  endtask

  task automatic test_invalid;
    int g0;
    g0 = got.size();
    issue(32'd2, 32'h1234);
    total++;
    if (err_invalid !== 1'b1 || sc_done !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL inv_pulse: err=%b done=%b ov=%b required 1 1 0",
                      err_invalid, sc_done, out_valid);
    end
    tick;
    total++;
    if (err_invalid !== 1'b0 || sc_done !== 1'b0 || stall !== 1'b0 || got.size() != g0) begin
      bad++; $display("FAIL inv_after: err=%b done=%b st=%b chars=%0d required 0 0 0 0",
                      err_invalid, sc_done, stall, got.size() - g0);
    end
  endtask

  task automatic test_random_strings;
    string s; int e, r;
    logic [31:0] w;
    logic [31:0] a;
    for (int wi = 32; wi < 48; wi++) begin
      w = '0;
      for (int bi = 0; bi < 4; bi++)
        if ($urandom_range(0, 5) != 0) w[8*bi +: 8] = 8'($urandom_range(8'h41, 8'h5A));
      mem[wi] = w;
    end
    mem[48] = '0;
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 32'($urandom_range(128, 187));
      str_model(a, s, e, r);
      check_service("str_rand", 32'd4, a, s, e, r);
    end
    rand_ready = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset_mid;
    int g0, n;
    g0 = got.size();
    issue(32'd4, 32'h10);
    n = 0;
    while (got.size() - g0 < 2 && n < 50) begin tick; n++; end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || stall !== 1'b0 || mem_ren !== 1'b0) begin
      bad++; $display("FAIL rstmid_out: ov=%b st=%b ren=%b required 0 0 0",
                      out_valid, stall, mem_ren);
    end
    tick;
    rst = 1'b0;
    tick;
    check_service("rstmid_again", 32'd4, 32'h10, "Hello!", 0, 2);
  endtask

  task automatic test_halt;
    int g0;
    g0 = got.size();
    issue(32'd10, 32'd0);
    total++;
    if (halt !== 1'b1 || stall !== 1'b1 || sc_done !== 1'b1) begin
      bad++; $display("FAIL halt_entry: h=%b st=%b dn=%b required 1 1 1", halt, stall, sc_done);
    end
    tick;
    issue(32'd1, 32'd55);
    repeat (4) tick;
    total++;
    if (halt !== 1'b1 || stall !== 1'b1 || sc_done !== 1'b0 || got.size() != g0) begin
      bad++; $display("FAIL halt_sticky: h=%b st=%b dn=%b chars=%0d required 1 1 0 0",
                      halt, stall, sc_done, got.size() - g0);
    end
    do_reset;
    total++;
    if (halt !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL halt_cleared: h=%b st=%b required 0 0", halt, stall);
    end
    check_service("post_halt", 32'd1, 32'd42, "42", 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[4]  = 32'h6C6C_6548;
    mem[5]  = 32'h0000_216F;
    mem[8]  = 32'h4443_4241;
    mem[9]  = 32'h4847_4645;
    mem[10] = 32'h4C4B_4A49;
    mem_rdata = '0;
    do_reset;
    test_reset;
    test_print_int;
    test_print_string;
    test_backpressure;
    test_overrun;
    test_invalid;
    test_random_strings;
    test_reset_mid;
    test_halt;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
